// File: rtl/theory_divider_param.sv
// theory_divider_param: multi-cycle restoring divider, signed/unsigned per op.
// One quotient bit per cycle; two per cycle when THEORY_DIVIDER_RADIX4_EN is
// defined (results are identical either way).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start_sig  in   request, accepted only while busy_sig=0
//   sgn        in   1 = two's complement operands, 0 = unsigned (sampled on accept)
//   dividend   in   W bits, sampled on accept
//   divisor    in   W bits, sampled on accept
//   busy_sig   out  operation in progress
//   done_sig   out  one-cycle pulse, results valid
//   quotient   out  W bits, registered
//   remainder  out  W bits, registered
//   dz_flag    out  last operation had divisor = 0
//   ovf_flag   out  last operation was signed MIN / -1
module theory_divider_param #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_sig,
  input  logic         sgn,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy_sig,
  output logic         done_sig,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz_flag,
  output logic         ovf_flag
);

`ifdef THEORY_DIVIDER_RADIX4_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;        // dividend shift register, collects quotient bits
  logic [W-1:0]  b_q, b_d;        // divisor magnitude
  logic [W-1:0]  r_q, r_d;        // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dzf_q, dzf_d;
  logic          ovff_q, ovff_d;

  logic [W-1:0]  dvd_mag_c;
  logic [W-1:0]  dvs_mag_c;
  logic [2*W-1:0] step_c;

  // One restoring step: returns {new partial remainder, shifted dividend/quotient}.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W:0] t;
    t = {r, a[W-1]};
    if (t >= {1'b0, b}) begin
      div_step = {W'(t - {1'b0, b}), a[W-2:0], 1'b1};
    end else begin
      div_step = {t[W-1:0], a[W-2:0], 1'b0};
    end
  endfunction

  assign dvd_mag_c = (sgn && dividend[W-1]) ? -dividend : dividend;
  assign dvs_mag_c = (sgn && divisor[W-1])  ? -divisor  : divisor;

`ifdef THEORY_DIVIDER_RADIX4_EN
  logic [2*W-1:0] step1_c;
  // Two cascaded steps per edge.
  assign step1_c = div_step(r_q, a_q, b_q);
  assign step_c  = div_step(step1_c[2*W-1:W], step1_c[W-1:0], b_q);
`else
  assign step_c  = div_step(r_q, a_q, b_q);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzf_q   <= 1'b0;
      ovff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzf_q   <= dzf_d;
      ovff_q  <= ovff_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzf_d   = dzf_q;
    ovff_d  = ovff_q;

    unique case (state_q)
      IDLE: begin
        if (start_sig && !busy_q) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          r_d    = '0;
          b_d    = dvs_mag_c;
          dz_d   = (divisor == '0);
          ovf_d  = sgn && (dividend == MIN_VAL) && (divisor == '1);
          qneg_d = sgn && (dividend[W-1] ^ divisor[W-1]);
          rneg_d = sgn && dividend[W-1];
          if (divisor == '0) begin
            // Divide by zero keeps the raw dividend for the remainder.
            a_d     = dividend;
            state_d = FIN;
          end else begin
            a_d     = dvd_mag_c;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = step_c[2*W-1:W];
        a_d   = step_c[W-1:0];
        cnt_d = cnt_q + CW'(STEP);
        if (cnt_d == CW'(W)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        if (dz_q) begin
          quot_d = '1;
          rem_d  = a_q;
        end else begin
          quot_d = qneg_q ? -a_q : a_q;
          rem_d  = rneg_q ? -r_q : r_q;
        end
        dzf_d   = dz_q;
        ovff_d  = ovf_q && !dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_sig  = busy_q;
  assign done_sig  = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz_flag   = dzf_q;
  assign ovf_flag  = ovff_q;

endmodule

// File: tb/tb_theory_divider_param.sv
// tb_theory_divider_param: directed vectors with a scoreboard queue; a monitor
// pops one expectation per done_sig pulse and checks results and latency.
module tb_theory_divider_param;

  localparam int unsigned W = 32;
`ifdef THEORY_DIVIDER_RADIX4_EN
  localparam int unsigned LAT = W / 2;
`else
  localparam int unsigned LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_sig;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy_sig;
  logic         done_sig;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz_flag;
  logic         ovf_flag;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  theory_divider_param #(.W(W), .CW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_sig (start_sig),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy_sig  (busy_sig),
    .done_sig  (done_sig),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_flag   (dz_flag),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_sig) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("quotient",     quotient,         e.q);
          chk("remainder",    remainder,        e.r);
          chk("dz_flag",      32'(dz_flag),     32'(e.dz));
          chk("ovf_flag",     32'(ovf_flag),    32'(e.ovf));
          chk("done_latency", 32'(cyc),         32'(e.cyc));
          chk("busy_at_done", 32'(busy_sig),    32'd0);
        end
      end
    end
  endtask

  // Drive one request at a negedge; the accept edge is the next posedge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eovf);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.ovf = eovf;
    e.cyc = cyc + 2 + ((b == 32'd0) ? 0 : LAT);
    sgn       = s;
    dividend  = a;
    divisor   = b;
    start_sig = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start_sig = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    sgn       = ~s;
    chk("busy_after_accept", 32'(busy_sig), 32'd1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (done_sig) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done_sig (t=%0t)", $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},      32'(busy_sig), 32'd0);
    chk({tag, "_done"},      32'(done_sig), 32'd0);
    chk({tag, "_quotient"},  quotient,      32'd0);
    chk({tag, "_remainder"}, remainder,     32'd0);
    chk({tag, "_dz"},        32'(dz_flag),  32'd0);
    chk({tag, "_ovf"},       32'(ovf_flag), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start_sig = 1'b0;
    sgn       = 1'b0;
    dividend  = '0;
    divisor   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned and signed cases.
    issue(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0); wait_done();
    issue(1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0); wait_done();
    issue(1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0); wait_done();
    issue(1'b0, 32'hFFFFFF9C,   32'd7,          32'h24924916,   32'd2,          1'b0, 1'b0); wait_done();
    // Signed overflow, then a clean op clears the flag.
    issue(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1); wait_done();
    issue(1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0); wait_done();
    // Divide by zero, both modes.
    issue(1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0); wait_done();
    issue(1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0); wait_done();
    // Boundaries: MIN/1 signed, divisor larger than dividend, max/max.
    issue(1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0); wait_done();
    issue(1'b0, 32'd3,          32'h80000000,   32'd0,          32'd3,          1'b0, 1'b0); wait_done();
    issue(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0); wait_done();

    // Start pulse while busy is ignored.
    issue(1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 1'b0);
    repeat (4) @(negedge clk);
    sgn = 1'b0; dividend = 32'd7; divisor = 32'd7; start_sig = 1'b1;
    @(negedge clk);
    start_sig = 1'b0;
    wait_done();

    // Back-to-back starts issued in the done cycle.
    issue(1'b0, 32'h0000FFFF,   32'd3,          32'h00005555,   32'd0,          1'b0, 1'b0); wait_done();
    issue(1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0); wait_done();
    issue(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0); wait_done();
    issue(1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1'b0); wait_done();

    // Reset at E0+10 discards the in-flight op and clears the outputs.
    sgn = 1'b0; dividend = 32'd50; divisor = 32'd3; start_sig = 1'b1;
    @(negedge clk);
    start_sig = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midop_reset");
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Recovery after reset.
    issue(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0); wait_done();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
